picoramsoc_ram_arbiter: RTL
===========================

// Module: picoramsoc_ram_arbiter
// PURPOSE
// - Shares data port 1 of picoramsoc_mem (22-bit word addr, 4-bit wen, 1-cycle registered read) between two masters.
// - m0 is the CPU data bus; m1 is a DMA/loader master. Both use the picorv32 valid/ready/wstrb protocol.
// - Claims only in-range requests (addr < 4*MEM_WORDS); other requests are left to the SoC decoders.
// - Round-robin by default; fixed priority to m0 when selected by parameter.
// PARAMETERS
// - MEM_WORDS     4096  RAM depth in 32-bit words; sets the claim window 0 .. 4*MEM_WORDS-1.
// - FIXED_PRIO    0     1 = m0 always wins ties; 0 = round-robin.
// - MAX_LOCK      8     Max back-to-back m1 grants while locked (PICORAMSOC_ARB_LOCK_EN only).
// PORTS
// - clk           in   1   Clock; all state on posedge.
// - resetn        in   1   Async active-low reset.
// - m0_valid      in   1   CPU request; held until m0_ready.
// - m0_ready      out  1   One-cycle completion pulse to CPU.
// - m0_addr       in   32  CPU byte address.
// - m0_wstrb      in   4   Byte write strobes; 0 = read.
// - m0_wdata      in   32  CPU write data.
// - m0_rdata      out  32  Read data; valid only while m0_ready=1.
// - m1_valid, m1_ready, m1_addr, m1_wstrb, m1_wdata, m1_rdata: as m0_*, for the DMA master.
// - m1_lock       in   1   Hold grant across m1 transactions (PICORAMSOC_ARB_LOCK_EN only).
// - ram_wen       out  4   Byte write enables to RAM.
// - ram_addr      out  22  Word address to RAM (= granted addr[23:2]).
// - ram_wdata     out  32  Write data to RAM.
// - ram_rdata     in   32  RAM read data, valid the cycle after ram_addr.
// - grant         out  2   One-hot owner: [0]=m0, [1]=m1; 00 when idle.
// - busy          out  1   High in ACCESS and RESP.
// BEHAVIOUR
// - Reset: state=IDLE, grant=00, last=m1 (so m0 wins the first tie), lock_cnt=0; all ready/wen=0; rdata=0; busy=0.
// - req_i = mi_valid && mi_addr < 4*MEM_WORDS. The compare is 32-bit unsigned.
// - FSM IDLE -> ACCESS -> RESP -> IDLE. Each state lasts exactly one cycle, except IDLE, which waits for a request.
// - IDLE: if any req, register the winner into grant and go to ACCESS. With no req, stay; ram_wen=0 and ram_addr holds.
// - Winner selection:
//   - Only one req: that master wins.
//   - Both req with FIXED_PRIO=1: m0 wins.
//   - Both req otherwise: the master != last wins.
// - ACCESS: ram_addr/ram_wdata come from the granted master; ram_wen = granted wstrb (1 cycle only); last <= granted.
// - RESP: granted mi_ready=1 and mi_rdata=ram_rdata; the other ready stays 0; then grant=00 and go to IDLE.
// - Latency: valid sampled in IDLE at cycle t -> ready at t+2. Minimum 3 cycles per transaction; IDLE always separates transactions.
// - The RESP cycle never re-grants, so the still-high valid is not double-counted.
// - Writes: each strobe byte is written exactly once. Read-during-write returns the old word (RAM semantics).
// - Valid dropped after grant is a protocol violation. The transaction still completes: the write commits and ready pulses.
// - Request arrives for the other master during ACCESS/RESP: it waits for the next IDLE. No request is lost while valid is held.
// - Async reset mid-ACCESS: wen drops immediately, so a partial write is possible only if the clock edge coincides. Mid-RESP: the ready pulse is suppressed.
// - Outputs are registered or decoded from state and grant only. There is no combinational path from ram_rdata except to mi_rdata.
// CONFIGURATION
// - Macro PICORAMSOC_ARB_LOCK_EN.
// - Defined:
//   - m1_lock port exists. If m1 held the grant with m1_lock=1 and m1 requests again in IDLE, m1 wins, overriding round-robin.
//   - lock_cnt counts consecutive locked grants. When it reaches MAX_LOCK and m0 requests, m0 wins and lock_cnt clears.
//   - lock_cnt clears on any m0 grant or when m1_lock=0.
// - Undefined: no m1_lock port and no lock_cnt; pure round-robin/fixed-priority arbitration as above.
// TESTING
// - Single read: m0 reads 0x100 holding 0xDEADBEEF -> m0_ready at t+2, m0_rdata=0xDEADBEEF, ram_wen=0 throughout.
// - Byte write: m1 writes 0x55 to 0x203 with wstrb=1000 -> ram_wen=1000 for one cycle; a later read of 0x200 returns 0x55 in byte 3, other bytes unchanged.
// - Tie: m0 and m1 both valid from reset -> m0 granted first, then m1. After 4 rounds, grants alternate m0,m1,m0,m1,...
// - Out of range: m0_addr=0x0200_0008 with MEM_WORDS=4096 -> no grant, m0_ready stays 0, ram_wen=0.
// - Reset: assert resetn=0 during ACCESS of a write -> grant=00, ram_wen=0, no ready. After release, m0 read completes in 2 cycles.
// - LOCK_EN with MAX_LOCK=2: m1_lock=1 with m0 waiting -> grants m1,m1,m0,m1,m1,m0.

Source files
------------

// File: rtl/picoramsoc_ram_arbiter_if.sv
// Bus bundle between the two RAM masters, the arbiter and RAM data port 1.
// m0_* : CPU data bus (picorv32 valid/ready/wstrb protocol)
// m1_* : DMA/loader master, same protocol; m1_lock only with PICORAMSOC_ARB_LOCK_EN
// ram_*: word-addressed RAM port (4-bit byte wen, registered 1-cycle read)
// grant/busy: arbiter status
// modport slave  : arbiter side
// modport master : masters + RAM side (used by the environment)
interface picoramsoc_ram_arbiter_if;
  logic        m0_valid, m0_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic        m1_valid, m1_ready;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wstrb;
`ifdef PICORAMSOC_ARB_LOCK_EN
  logic        m1_lock;
`endif
  logic [3:0]  ram_wen;
  logic [21:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [1:0]  grant;
  logic        busy;

`ifdef PICORAMSOC_ARB_LOCK_EN
  modport slave (
    input  m0_valid, m0_addr, m0_wstrb, m0_wdata,
    output m0_ready, m0_rdata,
    input  m1_valid, m1_addr, m1_wstrb, m1_wdata, m1_lock,
    output m1_ready, m1_rdata,
    output ram_wen, ram_addr, ram_wdata,
    input  ram_rdata,
    output grant, busy
  );
  modport master (
    output m0_valid, m0_addr, m0_wstrb, m0_wdata,
    input  m0_ready, m0_rdata,
    output m1_valid, m1_addr, m1_wstrb, m1_wdata, m1_lock,
    input  m1_ready, m1_rdata,
    input  ram_wen, ram_addr, ram_wdata,
    output ram_rdata,
    input  grant, busy
  );
`else
  modport slave (
    input  m0_valid, m0_addr, m0_wstrb, m0_wdata,
    output m0_ready, m0_rdata,
    input  m1_valid, m1_addr, m1_wstrb, m1_wdata,
    output m1_ready, m1_rdata,
    output ram_wen, ram_addr, ram_wdata,
    input  ram_rdata,
    output grant, busy
  );
  modport master (
    output m0_valid, m0_addr, m0_wstrb, m0_wdata,
    input  m0_ready, m0_rdata,
    output m1_valid, m1_addr, m1_wstrb, m1_wdata,
    input  m1_ready, m1_rdata,
    input  ram_wen, ram_addr, ram_wdata,
    output ram_rdata,
    input  grant, busy
  );
`endif
endinterface

// File: rtl/picoramsoc_ram_arbiter.sv
// Two-master arbiter for RAM data port 1 (CPU = m0, DMA/loader = m1).
// Only requests with addr < 4*MEM_WORDS are claimed. Each transaction runs
// IDLE -> ACCESS -> RESP; ready pulses two cycles after the IDLE sample.
// Ports: clk, resetn (async, active low), bus (picoramsoc_ram_arbiter_if.slave).
// Parameters: MEM_WORDS (claim window), FIXED_PRIO (1 = m0 wins ties),
//             MAX_LOCK (locked m1 grant limit).
// Optional feature: define PICORAMSOC_ARB_LOCK_EN to add m1_lock, which lets
// m1 keep the RAM across transactions for up to MAX_LOCK grants while m0 waits.
module picoramsoc_ram_arbiter #(
  parameter int unsigned MEM_WORDS  = 4096,
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned MAX_LOCK   = 8
) (
  input logic                      clk,
  input logic                      resetn,
  picoramsoc_ram_arbiter_if.slave  bus
);
  localparam logic [31:0] ADDR_LIM = 32'(4 * MEM_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic [1:0]  grant_q;
  logic        last;      // 1 = m1 was served last
  logic        m0_rdy_q, m1_rdy_q, busy_q;
  logic [3:0]  wen_q;
  logic [21:0] addr_q;
  logic [31:0] wdata_q;

  logic req0, req1, win1;
  assign req0 = bus.m0_valid && (bus.m0_addr < ADDR_LIM);
  assign req1 = bus.m1_valid && (bus.m1_addr < ADDR_LIM);

`ifdef PICORAMSOC_ARB_LOCK_EN
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  logic [CNT_W-1:0] lock_cnt;
  logic             lock_hold;  // last m1 grant was taken with m1_lock set
`endif

  always_comb begin
    win1 = req1 && (!req0 || (!FIXED_PRIO && !last));
`ifdef PICORAMSOC_ARB_LOCK_EN
    // A locked m1 keeps winning until it has used MAX_LOCK grants with m0 waiting.
    if (req1 && lock_hold && bus.m1_lock)
      win1 = !(req0 && (lock_cnt >= CNT_W'(MAX_LOCK)));
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      grant_q  <= 2'b00;
      last     <= 1'b1;
      m0_rdy_q <= 1'b0;
      m1_rdy_q <= 1'b0;
      busy_q   <= 1'b0;
      wen_q    <= 4'h0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      case (state)
        IDLE: if (req0 || req1) begin
          grant_q <= win1 ? 2'b10 : 2'b01;
          addr_q  <= win1 ? bus.m1_addr[23:2] : bus.m0_addr[23:2];
          wdata_q <= win1 ? bus.m1_wdata : bus.m0_wdata;
          wen_q   <= win1 ? bus.m1_wstrb : bus.m0_wstrb;
          busy_q  <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // RAM captures the write on this edge; read data lands in RESP.
          wen_q    <= 4'h0;
          last     <= grant_q[1];
          m0_rdy_q <= grant_q[0];
          m1_rdy_q <= grant_q[1];
          state    <= RESP;
        end
        RESP: begin
          // No grant here: the served master's valid is still high this cycle.
          m0_rdy_q <= 1'b0;
          m1_rdy_q <= 1'b0;
          grant_q  <= 2'b00;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PICORAMSOC_ARB_LOCK_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_cnt  <= '0;
      lock_hold <= 1'b0;
    end else if (state == IDLE && (req0 || req1)) begin
      if (win1) begin
        lock_hold <= bus.m1_lock;
        if (!bus.m1_lock)
          lock_cnt <= '0;
        else if (lock_cnt < CNT_W'(MAX_LOCK))
          lock_cnt <= lock_cnt + 1'b1;
      end else begin
        lock_hold <= 1'b0;
        lock_cnt  <= '0;
      end
    end else if (!bus.m1_lock) begin
      lock_cnt <= '0;
    end
  end
`endif

  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
  assign bus.ram_wen   = wen_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.m0_ready  = m0_rdy_q;
  assign bus.m1_ready  = m1_rdy_q;
  assign bus.m0_rdata  = m0_rdy_q ? bus.ram_rdata : 32'h0;
  assign bus.m1_rdata  = m1_rdy_q ? bus.ram_rdata : 32'h0;
endmodule
